// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: default widths, arctangent table and sequencer states.
// The table holds atan(2^-i) in units of deg*256/180 with 4 fractional bits.
package cordic_pkg;

  localparam int ITER_DEFAULT  = 8;
  localparam int CW_DEFAULT    = 19;
  localparam int ZF_DEFAULT    = 4;
  localparam int TAG_W_DEFAULT = 30;
  localparam int NV_MAX        = 4;

  localparam int ATAN_TAB [0:7] = '{1024, 605, 319, 162, 81, 41, 20, 10};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int atan_entry(input logic [2:0] i);
    return ATAN_TAB[i];
  endfunction

endpackage

// File: rtl/cordic_micro_rot.sv
// One CORDIC micro-rotation of a single vertex: shift-add with arithmetic
// shifts and natural CW-bit wrap. neg=1 rotates clockwise (d = -1).
module cordic_micro_rot
  import cordic_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic signed [CW-1:0] x,
  input  logic signed [CW-1:0] y,
  input  logic [2:0]           i,
  input  logic                 neg,
  output logic signed [CW-1:0] x_rot,
  output logic signed [CW-1:0] y_rot
);

  logic signed [CW-1:0] x_sh;
  logic signed [CW-1:0] y_sh;

  assign x_sh  = x >>> i;
  assign y_sh  = y >>> i;
  assign x_rot = neg ? (x + y_sh) : (x - y_sh);
  assign y_rot = neg ? (y - x_sh) : (y + x_sh);

endmodule

// File: rtl/cordic_rotation_sequencer.sv
// Iterative CORDIC rotation of up to four vertices through one shared
// micro-rotation stage, one vertex per cycle, with valid/ready on both sides.
module cordic_rotation_sequencer
  import cordic_pkg::*;
#(
  parameter int ITER  = ITER_DEFAULT,
  parameter int CW    = CW_DEFAULT,
  parameter int ZF    = ZF_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*CW-1:0]      in_vx,
  input  logic [4*CW-1:0]      in_vy,
  input  logic signed [8:0]    in_angle,
  input  logic                 in_enable,
  input  logic                 in_form,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*CW-1:0]      out_vx,
  output logic [4*CW-1:0]      out_vy,
  output logic                 out_form,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int ZW = 9 + ZF;
  localparam logic [2:0] I_LAST = 3'(ITER - 1);

  state_t state_reg;
  state_t state_next;

  logic signed [CW-1:0] vx_reg [NV_MAX];
  logic signed [CW-1:0] vy_reg [NV_MAX];
  logic signed [ZW-1:0] z_reg;
  logic [1:0]           k_reg;
  logic [2:0]           i_reg;
  logic                 form_reg;
  logic [TAG_W-1:0]     tag_reg;

  logic                 accept;
  logic                 rotating;
  logic                 last_vertex;
  logic                 last_slot;
  logic                 z_neg;
  logic [1:0]           k_last;
  logic signed [ZW-1:0] atan_z;
  logic signed [CW-1:0] cur_x;
  logic signed [CW-1:0] cur_y;
  logic signed [CW-1:0] rot_x;
  logic signed [CW-1:0] rot_y;

  assign accept      = in_valid && (state_reg == ST_IDLE);
  assign rotating    = (state_reg == ST_ROTATE);
  assign k_last      = form_reg ? 2'd2 : 2'd3;
  assign last_vertex = (k_reg == k_last);
  assign last_slot   = last_vertex && (i_reg == I_LAST);
  // Direction comes from z, which only moves on the last vertex of an iteration.
  assign z_neg       = z_reg[ZW-1];
  assign atan_z      = ZW'(atan_entry(i_reg));
  assign cur_x       = vx_reg[k_reg];
  assign cur_y       = vy_reg[k_reg];

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg == ST_ROTATE) || (state_reg == ST_DONE);
  assign out_form  = form_reg;
  assign out_tag   = tag_reg;

  cordic_micro_rot #(
    .CW(CW)
  ) u_micro_rot (
    .x     (cur_x),
    .y     (cur_y),
    .i     (i_reg),
    .neg   (z_neg),
    .x_rot (rot_x),
    .y_rot (rot_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (in_valid) begin
          state_next = in_enable ? ST_ROTATE : ST_DONE;
        end
      end
      ST_ROTATE: begin
        if (last_slot) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k_reg    <= '0;
      i_reg    <= '0;
      z_reg    <= '0;
      form_reg <= 1'b0;
      tag_reg  <= '0;
    end else if (accept) begin
      k_reg    <= '0;
      i_reg    <= '0;
      z_reg    <= {in_angle, {ZF{1'b0}}};
      form_reg <= in_form;
      tag_reg  <= in_tag;
    end else if (rotating) begin
      if (last_vertex) begin
        k_reg <= '0;
        i_reg <= i_reg + 3'd1;
        z_reg <= z_neg ? (z_reg + atan_z) : (z_reg - atan_z);
      end else begin
        k_reg <= k_reg + 2'd1;
      end
    end
  end

  // Vertex register file; the fourth vertex is cleared for triangles.
  for (genvar gi = 0; gi < NV_MAX; gi++) begin : g_vertex
    always_ff @(posedge clk) begin
      if (reset) begin
        vx_reg[gi] <= '0;
        vy_reg[gi] <= '0;
      end else if (accept) begin
        if ((gi == NV_MAX - 1) && in_form) begin
          vx_reg[gi] <= '0;
          vy_reg[gi] <= '0;
        end else begin
          vx_reg[gi] <= in_vx[gi*CW +: CW];
          vy_reg[gi] <= in_vy[gi*CW +: CW];
        end
      end else if (rotating && (k_reg == 2'(gi))) begin
        vx_reg[gi] <= rot_x;
        vy_reg[gi] <= rot_y;
      end
    end

    assign out_vx[gi*CW +: CW] = vx_reg[gi];
    assign out_vy[gi*CW +: CW] = vy_reg[gi];
  end

endmodule

// File: tb/tb_cordic_rotation_sequencer.sv
// Scoreboarded bench for cordic_rotation_sequencer: a reference model computes
// each expected result at accept time; a monitor pops and compares on handshake.
module tb_cordic_rotation_sequencer;

  localparam int CW    = 19;
  localparam int TAG_W = 30;
  localparam int ITER  = 8;
  localparam int ATAN_REF [8] = '{1024, 605, 319, 162, 81, 41, 20, 10};

  typedef struct {
    logic [4*CW-1:0]  vx;
    logic [4*CW-1:0]  vy;
    logic             form;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [4*CW-1:0]    in_vx = '0;
  logic [4*CW-1:0]    in_vy = '0;
  logic signed [8:0]  in_angle = '0;
  logic               in_enable = 1'b0;
  logic               in_form = 1'b0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [4*CW-1:0]    out_vx;
  logic [4*CW-1:0]    out_vy;
  logic               out_form;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   rx_count = 0;
  exp_t sb [$];

  cordic_rotation_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vx     (in_vx),
    .in_vy     (in_vy),
    .in_angle  (in_angle),
    .in_enable (in_enable),
    .in_form   (in_form),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vx    (out_vx),
    .out_vy    (out_vy),
    .out_form  (out_form),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int wrap(input int v);
    logic signed [CW-1:0] t;
    t = v[CW-1:0];
    return int'(t);
  endfunction

  function automatic logic [4*CW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [4*CW-1:0] r;
    r[0*CW +: CW] = a[CW-1:0];
    r[1*CW +: CW] = b[CW-1:0];
    r[2*CW +: CW] = c[CW-1:0];
    r[3*CW +: CW] = d[CW-1:0];
    return r;
  endfunction

  function automatic int coord(input logic [4*CW-1:0] v, input int k);
    logic signed [CW-1:0] t;
    t = v[k*CW +: CW];
    return int'(t);
  endfunction

  // Iteration-major reference: all vertices use the direction taken from z
  // at the start of each iteration.
  function automatic exp_t model(input logic [4*CW-1:0] vx, input logic [4*CW-1:0] vy,
                                 input logic signed [8:0] ang, input logic en,
                                 input logic form, input logic [TAG_W-1:0] tag);
    exp_t e;
    int x [4];
    int y [4];
    int z, nv, d, nx, ny;
    nv = form ? 3 : 4;
    for (int k = 0; k < 4; k++) begin
      x[k] = coord(vx, k);
      y[k] = coord(vy, k);
    end
    if (form) begin
      x[3] = 0;
      y[3] = 0;
    end
    if (en) begin
      z = int'(ang) * 16;
      for (int i = 0; i < ITER; i++) begin
        d = (z >= 0) ? 1 : -1;
        for (int k = 0; k < nv; k++) begin
          nx = wrap(x[k] - d * (y[k] >>> i));
          ny = wrap(y[k] + d * (x[k] >>> i));
          x[k] = nx;
          y[k] = ny;
        end
        z = z - d * ATAN_REF[i];
      end
    end
    e.vx   = pack4(x[0], x[1], x[2], x[3]);
    e.vy   = pack4(y[0], y[1], y[2], y[3]);
    e.form = form;
    e.tag  = tag;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        rx_count++;
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: got result tag=%h, required no result", out_tag);
        end else begin
          e = sb.pop_front();
          if (out_vx !== e.vx || out_vy !== e.vy || out_form !== e.form || out_tag !== e.tag) begin
            tests_failed++;
            $display("FAIL sb_result: got vx=%h vy=%h form=%b tag=%h, required vx=%h vy=%h form=%b tag=%h",
                     out_vx, out_vy, out_form, out_tag, e.vx, e.vy, e.form, e.tag);
          end
        end
      end
    end
  endtask

  // Returns at #1 after the accept edge with the expected result queued.
  task automatic send(input logic [4*CW-1:0] vx, input logic [4*CW-1:0] vy,
                      input logic signed [8:0] ang, input logic en, input logic form,
                      input logic [TAG_W-1:0] tag);
    int guard = 0;
    in_vx = vx; in_vy = vy; in_angle = ang; in_enable = en; in_form = form; in_tag = tag;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, guard);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(vx, vy, ang, en, form, tag));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Number of edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || !in_ready) && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    tests_run++;
    if (sb.size() != 0 || !in_ready) begin
      tests_failed++;
      $display("FAIL %s_drain: %0d results outstanding in_ready=%b, required 0 and 1", name, sb.size(), in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
    tests_run++;
    if (out_vx !== '0 || out_vy !== '0 || out_form !== 1'b0 || out_tag !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: vx=%h vy=%h form=%b tag=%h, required all 0", out_vx, out_vy, out_form, out_tag);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_passthrough();
    logic [4*CW-1:0] vx, vy;
    vx = pack4(-77, -77, 77, 77);
    vy = pack4(-77, 77, 77, -77);
    out_ready = 1'b1;
    send(vx, vy, 9'sd100, 1'b0, 1'b0, 30'h2BAD_CAFE);
    // Pass-through goes straight to DONE on the accept edge.
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL pass_latency: out_valid=%b on accept edge, required 1", out_valid);
    end
    tests_run++;
    if (out_vx !== vx || out_vy !== vy || out_tag !== 30'h2BAD_CAFE) begin
      tests_failed++;
      $display("FAIL pass_data: vx=%h vy=%h tag=%h, required vx=%h vy=%h tag=%h", out_vx, out_vy, out_tag, vx, vy, 30'h2BAD_CAFE);
    end
    drain("pass");
  endtask

  task automatic test_rot45();
    int lat;
    send(pack4(60, 0, 0, 0), pack4(0, 0, 0, 0), 9'sd64, 1'b1, 1'b0, 30'h0000_0045);
    wait_valid(lat);
    tests_run++;
    if (lat != 32) begin
      tests_failed++;
      $display("FAIL rot45_latency: %0d edges, required 32", lat);
    end
    tests_run++;
    if (coord(out_vx, 0) < 68 || coord(out_vx, 0) > 72 || coord(out_vy, 0) < 68 || coord(out_vy, 0) > 72) begin
      tests_failed++;
      $display("FAIL rot45_tol: v1=(%0d,%0d), required within 2 of (70,70)", coord(out_vx, 0), coord(out_vy, 0));
    end
    tests_run++;
    if (coord(out_vx, 0) != 69 || coord(out_vy, 0) != 71) begin
      tests_failed++;
      $display("FAIL rot45_exact: v1=(%0d,%0d), required (69,71)", coord(out_vx, 0), coord(out_vy, 0));
    end
    drain("rot45");
  endtask

  task automatic test_tri_m90();
    int lat;
    send(pack4(0, 10, -5, 50), pack4(-77, 3, 7, 50), -9'sd128, 1'b1, 1'b1, 30'h0000_0090);
    wait_valid(lat);
    tests_run++;
    if (lat != 24) begin
      tests_failed++;
      $display("FAIL tri_latency: %0d edges, required 24", lat);
    end
    tests_run++;
    if (coord(out_vx, 3) != 0 || coord(out_vy, 3) != 0 || out_form !== 1'b1) begin
      tests_failed++;
      $display("FAIL tri_v4: v4=(%0d,%0d) form=%b, required (0,0) form 1", coord(out_vx, 3), coord(out_vy, 3), out_form);
    end
    tests_run++;
    if (coord(out_vx, 0) != -129 || coord(out_vy, 0) != -2) begin
      tests_failed++;
      $display("FAIL tri_v1: v1=(%0d,%0d), required (-129,-2)", coord(out_vx, 0), coord(out_vy, 0));
    end
    drain("tri");
  endtask

  task automatic test_backpressure();
    logic [4*CW-1:0] snap_vx, snap_vy, vx2, vy2;
    int stable_bad = 0;
    out_ready = 1'b0;
    send(pack4(11, -22, 33, -44), pack4(-55, 66, -77, 1), 9'sd5, 1'b0, 1'b0, 30'h1111_1111);
    snap_vx = out_vx;
    snap_vy = out_vy;
    vx2 = pack4(20, 30, -40, 0);
    vy2 = pack4(-20, 5, 6, 7);
    in_vx = vx2; in_vy = vy2; in_angle = -9'sd30; in_enable = 1'b1; in_form = 1'b0; in_tag = 30'h2222_2222;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_vx !== snap_vx || out_vy !== snap_vy) stable_bad++;
    end
    tests_run++;
    if (stable_bad != 0) begin
      tests_failed++;
      $display("FAIL bp_stable: %0d unstable cycles, required 0", stable_bad);
    end
    sb.push_back(model(vx2, vy2, -9'sd30, 1'b1, 1'b0, 30'h2222_2222));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_accept: busy=%b in_ready=%b, required 1 0", busy, in_ready);
    end
    drain("bp");
  endtask

  task automatic test_reset_midflight();
    send(pack4(40, 40, 40, 40), pack4(-3, 3, -3, 3), 9'sd77, 1'b1, 1'b0, 30'h0BAD_0001);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset: in_ready=%b out_valid=%b busy=%b, required 1 0 0", in_ready, out_valid, busy);
    end
    reset = 1'b0;
    void'(sb.pop_back());
    send(pack4(-12, 34, 56, -70), pack4(7, -8, 9, 77), -9'sd45, 1'b1, 1'b0, 30'h0000_0F5E);
    drain("midreset");
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    int rx_before;
    rx_before = rx_count;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          logic [4*CW-1:0] vx, vy;
          logic signed [8:0] ang;
          for (int k = 0; k < 4; k++) begin
            int a, b;
            a = int'($urandom_range(0, 154)) - 77;
            b = int'($urandom_range(0, 154)) - 77;
            vx[k*CW +: CW] = a[CW-1:0];
            vy[k*CW +: CW] = b[CW-1:0];
          end
          ang = 9'($urandom_range(0, 511));
          send(vx, vy, ang, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), TAG_W'($urandom()));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("b2b");
    tests_run++;
    if (rx_count - rx_before != 1000) begin
      tests_failed++;
      $display("FAIL b2b_count: %0d results, required 1000", rx_count - rx_before);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_passthrough();
    test_rot45();
    test_tri_m90();
    test_backpressure();
    test_reset_midflight();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
